// File: rtl/rvh_l1d_snp_ctrl.sv
// L1D snoop controller: buffers ACE AC snoops in order and sequences lookup, CR response and CD data per snoop.
// Optional snoop statistics counters are enabled with `define RVH_L1D_SNP_CNT_EN.
module rvh_l1d_snp_ctrl #(
    parameter int unsigned SNP_BUF_DEPTH = 32'd4,
    parameter int unsigned PADDR_W       = 32'd56,
    parameter int unsigned LINE_W        = 32'd512,
    parameter int unsigned CD_W          = 32'd128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ac_valid_i,
    output logic               ac_ready_o,
    input  logic [PADDR_W-1:0] ac_addr_i,
    input  logic [3:0]         ac_snoop_i,
    output logic               snp_lkup_vld_o,
    input  logic               snp_lkup_rdy_i,
    output logic [PADDR_W-1:0] snp_lkup_addr_o,
    output logic               snp_lkup_inv_o,
    output logic               snp_lkup_shr_o,
    input  logic               snp_lkup_resp_vld_i,
    input  logic               snp_lkup_hit_i,
    input  logic               snp_lkup_dirty_i,
    input  logic               snp_lkup_unique_i,
    input  logic [LINE_W-1:0]  snp_lkup_data_i,
    output logic               cr_valid_o,
    input  logic               cr_ready_i,
    output logic [4:0]         cr_resp_o,
    output logic               cd_valid_o,
    input  logic               cd_ready_i,
    output logic [CD_W-1:0]    cd_data_o,
    output logic               cd_last_o
`ifdef RVH_L1D_SNP_CNT_EN
    ,
    output logic [31:0]        snp_cnt_o
`endif
);

    localparam int unsigned PTR_W    = $clog2(SNP_BUF_DEPTH);
    localparam int unsigned CD_BEATS = LINE_W / CD_W;
    localparam int unsigned BEAT_W   = (CD_BEATS > 32'd1) ? $clog2(CD_BEATS) : 32'd1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CD_BEATS - 32'd1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(32'd1);
    localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W + 1)'(32'd1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LKUP = 3'd1,
        ST_WAIT = 3'd2,
        ST_CR   = 3'd3,
        ST_CD   = 3'd4
    } state_e;

    typedef struct packed {
        logic [PADDR_W-1:0] addr;
        logic               inv;
        logic               shr;
        logic               ret_clean;
        logic               ret_dirty;
    } snp_ent_t;

    // Returns {inv, shr, ret_clean, ret_dirty}; unknown codes behave like ReadNotSharedDirty.
    function automatic logic [3:0] snp_decode(input logic [3:0] code);
        logic [3:0] flags;
        case (code)
            4'b0111: flags = 4'b1011;
            4'b1001: flags = 4'b1001;
            default: flags = 4'b0111;
        endcase
        return flags;
    endfunction

    snp_ent_t          buf_r [SNP_BUF_DEPTH];
    logic [PTR_W:0]    wr_ptr_r;
    logic [PTR_W:0]    rd_ptr_r;
    snp_ent_t          work_r;
    state_e            state_r;
    state_e            state_nxt_s;
    logic              lkup_vld_r;
    logic              cr_vld_r;
    logic              cd_vld_r;
    logic [4:0]        cr_resp_r;
    logic [LINE_W-1:0] data_r;
    logic [BEAT_W-1:0] beat_r;
    logic              cd_last_r;

    logic              empty_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic              cap_s;
    logic              cr_hs_s;
    logic              cd_hs_s;
    logic              dt_s;
    logic [4:0]        resp_nxt_s;
    logic [BEAT_W-1:0] beat_nxt_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                     (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign push_s  = ac_valid_i && !full_s;

    assign dt_s       = snp_lkup_hit_i && (snp_lkup_dirty_i ? work_r.ret_dirty : work_r.ret_clean);
    assign resp_nxt_s = {snp_lkup_hit_i && snp_lkup_unique_i,
                         snp_lkup_hit_i && !work_r.inv,
                         dt_s && snp_lkup_dirty_i,
                         1'b0,
                         dt_s};
    assign beat_nxt_s = beat_r + BEAT_ONE;

    // Snoop buffer storage and pointers; the pop only ever happens from IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int unsigned i = 0; i < SNP_BUF_DEPTH; i++) begin
                buf_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                buf_r[wr_ptr_r[PTR_W-1:0]] <= {ac_addr_i, snp_decode(ac_snoop_i)};
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and per-cycle handshake strobes.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        cap_s       = 1'b0;
        cr_hs_s     = 1'b0;
        cd_hs_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_LKUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LKUP: begin
                if (snp_lkup_rdy_i) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_LKUP;
                end
            end
            ST_WAIT: begin
                if (snp_lkup_resp_vld_i) begin
                    cap_s       = 1'b1;
                    state_nxt_s = ST_CR;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_CR: begin
                if (cr_ready_i) begin
                    cr_hs_s     = 1'b1;
                    state_nxt_s = cr_resp_r[0] ? ST_CD : ST_IDLE;
                end else begin
                    state_nxt_s = ST_CR;
                end
            end
            ST_CD: begin
                if (cd_ready_i) begin
                    cd_hs_s     = 1'b1;
                    state_nxt_s = cd_last_r ? ST_IDLE : ST_CD;
                end else begin
                    state_nxt_s = ST_CD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Registered valids follow the next state so they rise together with the state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lkup_vld_r <= 1'b0;
            cr_vld_r   <= 1'b0;
            cd_vld_r   <= 1'b0;
        end else begin
            lkup_vld_r <= (state_nxt_s == ST_LKUP);
            cr_vld_r   <= (state_nxt_s == ST_CR);
            cd_vld_r   <= (state_nxt_s == ST_CD);
        end
    end

    // Working snoop, captured response and CD beat shifter (lowest beat always at the bottom).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work_r    <= '0;
            cr_resp_r <= 5'b00000;
            data_r    <= '0;
            beat_r    <= '0;
            cd_last_r <= 1'b0;
        end else begin
            if (pop_s) begin
                work_r <= buf_r[rd_ptr_r[PTR_W-1:0]];
            end
            if (cap_s) begin
                cr_resp_r <= resp_nxt_s;
                data_r    <= snp_lkup_data_i;
            end
            if (cr_hs_s && cr_resp_r[0]) begin
                beat_r    <= '0;
                cd_last_r <= (CD_BEATS == 32'd1);
            end else if (cd_hs_s) begin
                data_r    <= data_r >> CD_W;
                beat_r    <= beat_nxt_s;
                cd_last_r <= cd_last_r ? 1'b0 : (beat_nxt_s == LAST_BEAT);
            end
        end
    end

`ifdef RVH_L1D_SNP_CNT_EN
    logic [15:0] snoop_cnt_r;
    logic [15:0] hit_dirty_cnt_r;

    // Saturating statistics, bumped on every CR handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snoop_cnt_r     <= 16'h0000;
            hit_dirty_cnt_r <= 16'h0000;
        end else if (cr_hs_s) begin
            if (snoop_cnt_r != 16'hFFFF) begin
                snoop_cnt_r <= snoop_cnt_r + 16'h0001;
            end
            if (cr_resp_r[2] && (hit_dirty_cnt_r != 16'hFFFF)) begin
                hit_dirty_cnt_r <= hit_dirty_cnt_r + 16'h0001;
            end
        end
    end

    assign snp_cnt_o = {hit_dirty_cnt_r, snoop_cnt_r};
`endif

    assign ac_ready_o      = !full_s;
    assign snp_lkup_vld_o  = lkup_vld_r;
    assign snp_lkup_addr_o = work_r.addr;
    assign snp_lkup_inv_o  = work_r.inv;
    assign snp_lkup_shr_o  = work_r.shr;
    assign cr_valid_o      = cr_vld_r;
    assign cr_resp_o       = cr_resp_r;
    assign cd_valid_o      = cd_vld_r;
    assign cd_data_o       = data_r[CD_W-1:0];
    assign cd_last_o       = cd_last_r;

endmodule
